// File: rtl/pong_ball_engine_if.sv
// pong_ball_engine_if: groups the signals between the raster driver/renderer
// and the ball engine.
// master = driver/renderer side (raster counters, player input).
// slave  = ball engine.
interface pong_ball_engine_if;
  logic [9:0] X_pix;
  logic [9:0] Y_pix;
  logic [9:0] paddle_y;
  logic       serve;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       in_play;
  logic       miss_pulse;
  logic [7:0] hit_count;
  logic [3:0] miss_count;

  modport master (
    output X_pix, Y_pix, paddle_y, serve,
    input  ball_x, ball_y, in_play, miss_pulse, hit_count, miss_count
  );

  modport slave (
    input  X_pix, Y_pix, paddle_y, serve,
    output ball_x, ball_y, in_play, miss_pulse, hit_count, miss_count
  );
endinterface

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: per-frame ball physics feeding the VGA renderer.
// The ball moves once per frame, on the tick at the start of vertical blank.
// It bounces off the top, bottom and right walls and off the left paddle.
// A miss is detected and the engine runs the serve / play / miss-hold sequence.
// Optional feature macro: PONG_SPEEDUP_EN. When it is defined, every paddle
// hit raises the step by 1, up to MAX_SPEED.
module pong_ball_engine #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 4,
  parameter int PADDLE_X    = 0,
  parameter int PADDLE_W    = 5,
  parameter int PADDLE_H    = 50,
  parameter int SPEED       = 2,
  parameter int MAX_SPEED   = 6,
  parameter int MISS_FRAMES = 60,
  parameter int SERVE_X     = 320,
  parameter int SERVE_Y     = 240
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  pong_ball_engine_if.slave  bus
);

  // The step register is sized for the larger of SPEED and MAX_SPEED.
  // The same width therefore holds in both builds.
  localparam int STEP_CAP = (MAX_SPEED > SPEED) ? MAX_SPEED : SPEED;
  localparam int STEP_W   = $clog2(STEP_CAP + 1);
  localparam int FC_W     = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

  localparam logic [10:0] LP_H_RES  = 11'(H_RES);
  localparam logic [10:0] LP_V_RES  = 11'(V_RES);
  localparam logic [10:0] LP_BALL   = 11'(BALL_SIZE);
  localparam logic [10:0] LP_PAD_R  = 11'(PADDLE_X + PADDLE_W);
  localparam logic [10:0] LP_PAD_H  = 11'(PADDLE_H);
  localparam logic [9:0]  LP_TICK_Y = 10'(V_RES);
  localparam logic [9:0]  LP_SRV_X  = 10'(SERVE_X);
  localparam logic [9:0]  LP_SRV_Y  = 10'(SERVE_Y);
  localparam logic [9:0]  LP_RGT_X  = 10'(H_RES - BALL_SIZE);
  localparam logic [9:0]  LP_BOT_Y  = 10'(V_RES - BALL_SIZE);
  localparam logic [9:0]  LP_PAD_RX = 10'(PADDLE_X + PADDLE_W);
  localparam logic [FC_W-1:0]   LP_FC_LAST = FC_W'(MISS_FRAMES - 1);
  localparam logic [STEP_W-1:0] LP_SPEED   = STEP_W'(SPEED);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_MISS} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_cond_d;
  logic              w_cond, w_tick;
  logic [9:0]        r_ball_x, r_ball_y, w_ball_x_nxt, w_ball_y_nxt;
  logic              r_dir_x, r_dir_y, w_dir_x_nxt, w_dir_y_nxt;
  logic [7:0]        r_hit_cnt;
  logic [3:0]        r_miss_cnt;
  logic [FC_W-1:0]   r_frame_cnt, w_frame_cnt_nxt;
  logic              r_in_play, r_miss_pulse;
  logic              w_hit_ev, w_miss_ev;
  logic [STEP_W-1:0] w_step;
  logic [9:0]        w_step10;
  logic [10:0]       w_bx, w_by, w_step11, w_pad11;
  logic [9:0]        w_x_dec, w_x_inc, w_y_dec, w_y_inc;
  logic              w_left_free, w_paddle_ovl, w_right_free, w_up_free, w_down_free;

  // Frame tick: the first cycle of the raster position (0, V_RES).
  // The driver can hold that position for several clocks. Comparing with the
  // registered copy of the condition gives exactly one tick per frame.
  assign w_cond = (bus.X_pix == '0) && (bus.Y_pix == LP_TICK_Y);
  assign w_tick = w_cond & ~r_cond_d;

  // Remember the tick condition from the previous clock.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) r_cond_d <= 1'b0;
    else        r_cond_d <= w_cond;
  end

`ifdef PONG_SPEEDUP_EN
  localparam logic [STEP_W-1:0] LP_CAP = STEP_W'(STEP_CAP);
  logic              w_serve_ev;
  logic [STEP_W-1:0] r_step;
  assign w_serve_ev = w_tick && (r_state == S_IDLE) && bus.serve;

  // Step speeds up on each hit. It reloads to SPEED when the ball is served.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)                          r_step <= LP_SPEED;
    else if (w_serve_ev)                 r_step <= LP_SPEED;
    else if (w_hit_ev && r_step < LP_CAP) r_step <= r_step + 1'b1;
  end
  assign w_step = r_step;
`else
  assign w_step = LP_SPEED;
`endif

  // Wall and paddle tests use 11 bits, so ball + size + step cannot wrap.
  assign w_step10 = 10'(w_step);
  assign w_step11 = {1'b0, w_step10};
  assign w_bx     = {1'b0, r_ball_x};
  assign w_by     = {1'b0, r_ball_y};
  assign w_pad11  = {1'b0, bus.paddle_y};

  assign w_left_free  = w_bx >= (LP_PAD_R + w_step11);
  assign w_paddle_ovl = ((w_by + LP_BALL) > w_pad11) && (w_by < (w_pad11 + LP_PAD_H));
  assign w_right_free = (w_bx + LP_BALL + w_step11) <= LP_H_RES;
  assign w_up_free    = w_by >= w_step11;
  assign w_down_free  = (w_by + LP_BALL + w_step11) <= LP_V_RES;

  // These are used only on paths where the guards above rule out overflow.
  assign w_x_dec = r_ball_x - w_step10;
  assign w_x_inc = r_ball_x + w_step10;
  assign w_y_dec = r_ball_y - w_step10;
  assign w_y_inc = r_ball_y + w_step10;

  // Next state and next ball position. Nothing changes outside the tick cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_ball_x_nxt    = r_ball_x;
    w_ball_y_nxt    = r_ball_y;
    w_dir_x_nxt     = r_dir_x;
    w_dir_y_nxt     = r_dir_y;
    w_frame_cnt_nxt = r_frame_cnt;
    w_hit_ev        = 1'b0;
    w_miss_ev       = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          w_ball_x_nxt = LP_SRV_X;
          w_ball_y_nxt = LP_SRV_Y;
          if (bus.serve) begin
            w_state_nxt = S_PLAY;
            w_dir_x_nxt = 1'b0;
            w_dir_y_nxt = ~r_dir_y;  // alternate the serve angle
          end
        end
        S_PLAY: begin
          if (!r_dir_x) begin
            if (w_left_free) begin
              w_ball_x_nxt = w_x_dec;
            end else if (w_paddle_ovl) begin
              w_ball_x_nxt = LP_PAD_RX;
              w_dir_x_nxt  = 1'b1;
              w_hit_ev     = 1'b1;
            end else begin
              w_ball_x_nxt = '0;
              w_state_nxt  = S_MISS;
              w_miss_ev    = 1'b1;
            end
          end else if (w_right_free) begin
            w_ball_x_nxt = w_x_inc;
          end else begin
            w_ball_x_nxt = LP_RGT_X;
            w_dir_x_nxt  = 1'b0;
          end
          // Y moves independently of X. It also moves on the tick of a miss.
          if (!r_dir_y) begin
            if (w_up_free) w_ball_y_nxt = w_y_dec;
            else begin
              w_ball_y_nxt = '0;
              w_dir_y_nxt  = 1'b1;
            end
          end else if (w_down_free) begin
            w_ball_y_nxt = w_y_inc;
          end else begin
            w_ball_y_nxt = LP_BOT_Y;
            w_dir_y_nxt  = 1'b0;
          end
        end
        S_MISS: begin
          if (r_frame_cnt == LP_FC_LAST) begin
            w_state_nxt     = S_IDLE;
            w_frame_cnt_nxt = '0;
            w_ball_x_nxt    = LP_SRV_X;
            w_ball_y_nxt    = LP_SRV_Y;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, ball, direction and frame counter registers.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ball_x    <= LP_SRV_X;
      r_ball_y    <= LP_SRV_Y;
      r_dir_x     <= 1'b0;
      r_dir_y     <= 1'b1;
      r_frame_cnt <= '0;
      r_in_play   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ball_x    <= w_ball_x_nxt;
      r_ball_y    <= w_ball_y_nxt;
      r_dir_x     <= w_dir_x_nxt;
      r_dir_y     <= w_dir_y_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_in_play   <= (w_state_nxt == S_PLAY);
    end
  end

  // Score counters. Hits wrap; misses saturate at 15. The miss pulse lasts one cycle.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_miss_pulse <= w_miss_ev;
      if (w_hit_ev)                           r_hit_cnt  <= r_hit_cnt + 8'd1;
      if (w_miss_ev && (r_miss_cnt != 4'hF))  r_miss_cnt <= r_miss_cnt + 4'd1;
    end
  end

  assign bus.ball_x     = r_ball_x;
  assign bus.ball_y     = r_ball_y;
  assign bus.in_play    = r_in_play;
  assign bus.miss_pulse = r_miss_pulse;
  assign bus.hit_count  = r_hit_cnt;
  assign bus.miss_count = r_miss_cnt;

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Game-physics stage directly upstream of the VGA top-level renderer.
- Owns the ball position and supplies ball_x/ball_y to the renderer's ball box. The renderer draws whatever this block outputs.
- Moves the ball once per frame, during vertical blank. Bounces it off the top, bottom and right walls and off the player-1 paddle on the left.
- Detects a miss and sequences serve / play / miss-hold. Runs on the driver's pixel clock and consumes the driver's X_pix/Y_pix raster counters.

Parameters:
- H_RES, 640: visible width in pixels.
- V_RES, 480: visible height; frame tick fires at Y_pix==V_RES.
- BALL_SIZE, 4: ball width and height in pixels.
- PADDLE_X, 0: paddle left edge.
- PADDLE_W, 5: paddle width.
- PADDLE_H, 50: paddle height.
- SPEED, 2: step per frame on each axis.
- MAX_SPEED, 6: step ceiling, used only with SPEEDUP_EN.
- MISS_FRAMES, 60: frames held in MISS before returning to IDLE.
- SERVE_X, 320 / SERVE_Y, 240: ball reset and serve position.

Ports:
- pixel_clk  in  1  pixel clock from the VGA driver.
- rst_n  in  1  asynchronous, active-low reset.
- X_pix  in  10  driver raster X.
- Y_pix  in  10  driver raster Y.
- paddle_y  in  10  paddle top edge (player input).
- serve  in  1  level; requests a serve while in IDLE.
- ball_x  out  10  ball left edge.
- ball_y  out  10  ball top edge.
- in_play  out  1  high in PLAY.
- miss_pulse  out  1  one-cycle pulse on a miss.
- hit_count  out  8  paddle hits; wraps 255 to 0.
- miss_count  out  4  misses; saturates at 15.

Behaviour:
- Clock and reset: one clock (pixel_clk). Reset is asynchronous, active-low (rst_n). All state is in flops cleared by rst_n.
- Reset values:
  - ball_x=SERVE_X, ball_y=SERVE_Y.
  - state=IDLE; dir_x=0 (left); dir_y=1 (down).
  - step=SPEED; hit_count=0; miss_count=0.
  - in_play=0; miss_pulse=0; frame counter=0.
  - Reset asserted mid-play returns to these values immediately.
- Frame tick:
  - cond = (X_pix==0 && Y_pix==V_RES); cond_d is cond registered.
  - tick = cond & ~cond_d, so there is exactly one tick per frame.
  - All state updates on the pixel_clk edge that ends the tick cycle (1-cycle latency). Outputs are otherwise constant, so the frame is tear-free.
- State machine (transitions only on tick):
  - IDLE: ball held at SERVE_X/SERVE_Y. If serve==1 then PLAY, dir_x=0, dir_y toggles (alternating serve angle), step=SPEED. Serve is ignored outside IDLE.
  - PLAY: motion rules below.
  - MISS: frame counter increments each tick. When it reaches MISS_FRAMES-1, go to IDLE, clear the counter and reload the serve position. MISS_FRAMES=1 means one tick in MISS.
- Motion in PLAY (11-bit unsigned arithmetic, no wrap):
  - Left, dir_x=0: if ball_x >= PADDLE_X+PADDLE_W+step, then ball_x -= step.
  - Otherwise paddle overlap is checked against paddle_y sampled in the tick cycle: ball_y+BALL_SIZE > paddle_y AND ball_y < paddle_y+PADDLE_H.
    - Hit: ball_x=PADDLE_X+PADDLE_W, dir_x=1, hit_count+1.
    - Miss: ball_x=0, state MISS, miss_count+1 (saturating), miss_pulse=1 for one cycle.
  - Right, dir_x=1: if ball_x+BALL_SIZE+step <= H_RES, then ball_x += step; else ball_x=H_RES-BALL_SIZE, dir_x=0.
  - Up, dir_y=0: if ball_y >= step, then ball_y -= step; else ball_y=0, dir_y=1.
  - Down, dir_y=1: if ball_y+BALL_SIZE+step <= V_RES, then ball_y += step; else ball_y=V_RES-BALL_SIZE, dir_y=0.
  - X and Y are evaluated independently in the same tick; a corner bounces both axes at once.
  - On a miss tick, y still updates normally.
- in_play is registered and equals (state==PLAY).

Optional Feature:
- Macro: PONG_SPEEDUP_EN.
- Defined: each paddle hit sets step=min(step+1, MAX_SPEED), effective from the next tick. step reloads to SPEED on serve and reset.
- Undefined: step is constant SPEED; MAX_SPEED is unused.

Test Plan:
1. Reset, no serve, 3 frames -> ball stays (320,240); in_play=0; counts 0.
2. Serve=1 at one tick -> next tick ball_x=318, ball_y=238 (dir_y toggled to up); in_play=1. Serve held further is ignored.
3. Ball at x=6 moving left, paddle_y=ball_y-10 -> tick gives ball_x=5, dir_x=1, hit_count=1; next tick ball_x=7.
4. Ball at x=6 moving left, paddle_y=ball_y+100 -> ball_x=0, miss_pulse high exactly 1 cycle, miss_count=1. After 60 ticks: IDLE at (320,240).
5. Ball at (635,477) moving right and down -> one tick gives (636,476) with both directions reversed.
6. Misses 16 times -> miss_count stays 15. Assert rst_n low mid-PLAY -> outputs return to reset values without waiting for pixel_clk.
7. With PONG_SPEEDUP_EN: 5 hits -> step=6 and stays 6 on further hits; next serve -> step=2.
